// File: rtl/deserializer_sipo.sv
// Serial-in/parallel-out receiver: assembles LSB-first frames into DATA_WIDTH-bit words on a valid/ready port.
// Optional even-parity bit per frame when DESER_PARITY_EN is defined.
module deserializer_sipo #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  srl_in,
    input  logic                  srl_en,
    input  logic                  srl_sof,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  ovr_clr,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] sr, sr_shift, word;
    logic [CNT_W-1:0]      cnt;
    logic                  load_bit, first_bit, complete, resync;

    assign sr_shift = {srl_in, sr[DATA_WIDTH-1:1]};
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        load_bit  = 1'b0;
        first_bit = 1'b0;
        complete  = 1'b0;
        resync    = 1'b0;
        case (state)
            IDLE: begin
                if (srl_en && srl_sof) begin
                    load_bit  = 1'b1;
                    first_bit = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (srl_en) begin
                    load_bit = 1'b1;
                    if (srl_sof) begin
                        first_bit = 1'b1;
                        resync    = 1'b1;
                    end else if (cnt == CNT_LAST) begin
`ifdef DESER_PARITY_EN
                        state_nxt = PARITY;
`else
                        complete  = 1'b1;
                        state_nxt = IDLE;
`endif
                    end
                end
            end
            PARITY: begin
                // The parity bit itself is never shifted into sr; a sof here restarts the frame.
                if (srl_en) begin
                    if (srl_sof) begin
                        load_bit  = 1'b1;
                        first_bit = 1'b1;
                        resync    = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DESER_PARITY_EN
    logic parity_q;
    assign word       = sr;
    assign parity_err = parity_q;

    always_ff @(posedge clk) begin
        if (!rst)
            parity_q <= 1'b0;
        else if (complete && (!data_valid || data_ready))
            parity_q <= (^sr) ^ srl_in;
    end
`else
    assign word       = sr_shift;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_err <= resync;
            if (load_bit)
                sr <= sr_shift;
            if (state_nxt == IDLE)
                cnt <= '0;
            else if (first_bit)
                cnt <= CNT_ONE;
            else if (load_bit)
                cnt <= cnt + CNT_ONE;

            // output stage: a completed word either loads or is dropped as an overrun
            if (complete && (!data_valid || data_ready)) begin
                data_out   <= word;
                data_valid <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end

            if (complete && data_valid && !data_ready)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deserializer_sipo.sv
// Bench for deserializer_sipo: directed table, hand sequences and random traffic vs. a bit-queue model.
// Handles both builds (DESER_PARITY_EN defined or not).
module tb_deserializer_sipo;
    localparam int W = 8;
`ifdef DESER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0, srl_in = 1'b0, srl_en = 1'b0, srl_sof = 1'b0;
    logic data_ready = 1'b0, ovr_clr = 1'b0;
    logic [W-1:0] data_out;
    logic data_valid, busy, overrun, frame_err, parity_err;

    deserializer_sipo #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .srl_in(srl_in), .srl_en(srl_en), .srl_sof(srl_sof),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, nvalid = 0, nferr = 0;

    // Reference model: the frame is a queue of received bits; a word is the sum of its bits by position.
    bit           q[$];
    bit           m_in_frame = 1'b0;
    logic [W-1:0] m_data = '0;
    bit           m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model();
        bit           done = 1'b0;
        bit           par = 1'b0;
        bit           ferr = 1'b0;
        logic [W-1:0] w = '0;
        if (!rst) begin
            q.delete();
            m_in_frame = 1'b0; m_data = '0; m_valid = 1'b0;
            m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
            return;
        end
        if (srl_en) begin
            if (srl_sof) begin
                ferr = m_in_frame;
                q.delete();
                q.push_back(srl_in);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                q.push_back(srl_in);
                if (q.size() == W + PB) begin
                    done = 1'b1;
                    m_in_frame = 1'b0;
                    for (int i = 0; i < W; i++) w[i] = q[i];
                    foreach (q[i]) par ^= q[i];
                    q.delete();
                end
            end
        end
        if (done && m_valid && !data_ready) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
        if (done && (!m_valid || data_ready)) begin
            m_data  = w;
            m_valid = 1'b1;
            m_perr  = (PB == 1) ? par : 1'b0;
        end else if (data_ready) begin
            m_valid = 1'b0;
        end
        m_ferr = ferr;
    endfunction

    task automatic step(input logic r, input logic en, input logic sof, input logic din,
                        input logic rdy, input logic clr);
        rst = r; srl_en = en; srl_sof = sof; srl_in = din; data_ready = rdy; ovr_clr = clr;
        @(posedge clk);
        model();
        #1;
        check("data_valid", data_valid, m_valid);
        check("data_out",   data_out,   m_data);
        check("busy",       busy,       m_in_frame);
        check("overrun",    overrun,    m_ovr);
        check("frame_err",  frame_err,  m_ferr);
        check("parity_err", parity_err, m_perr);
        if (data_valid) nvalid++;
        if (frame_err) nferr++;
    endtask

    // pbit < 0 sends the correct even-parity bit
    task automatic send_word(input logic [W-1:0] w, input int gap, input logic rdy, input int pbit);
        for (int i = 0; i < W; i++) begin
            repeat (gap) step(1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
            step(1'b1, 1'b1, (i == 0), w[i], rdy, 1'b0);
        end
        if (PB == 1) begin
            repeat (gap) step(1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
            step(1'b1, 1'b1, 1'b0, (pbit < 0) ? ^w : pbit[0], rdy, 1'b0);
        end
    endtask

    typedef struct {
        logic         r, en, sof, din, rdy;
        logic [W-1:0] e_data;
        logic         e_valid, e_busy;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [7:0] a5 = 8'hA5;
        int n0;
        bit last;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            last = (i == 7) && (PB == 0);
            tbl[i+1] = '{1'b1, 1'b1, (i == 0), a5[i], 1'b1, last ? a5 : 8'h00, last, !last};
        end
        if (PB == 1) tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a5, 1'b1, 1'b0};
        else         tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a5, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a5, 1'b0, 1'b0};

        // 0xA5 at full rate, including reset state
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, tbl[i].en, tbl[i].sof, tbl[i].din, tbl[i].rdy, 1'b0);
            check("t1_data",  data_out,   tbl[i].e_data);
            check("t1_valid", data_valid, tbl[i].e_valid);
            check("t1_busy",  busy,       tbl[i].e_busy);
            if (i == 0) check("t1_rst_ovr", {overrun, frame_err, parity_err}, 3'b000);
        end

        // bit enable every third cycle
        n0 = nvalid;
        send_word(8'h3C, 2, 1'b1, -1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_data", data_out, 8'h3C);
        check("t2_nvalid", nvalid - n0, 1);

        // overrun with ready low, then consume and clear
        send_word(8'h11, 0, 1'b0, -1);
        send_word(8'h22, 0, 1'b0, -1);
        check("t3_data", data_out, 8'h11);
        check("t3_ovr", overrun, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_consumed", data_valid, 1'b0);
        check("t3_ovr_hold", overrun, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t3_ovr_clr", overrun, 1'b0);

        // resync after 4 bits
        n0 = nvalid;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        nferr = 0;
        send_word(8'h5A, 0, 1'b1, -1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_ferr_pulses", nferr, 1);
        check("t4_nvalid", nvalid - n0, 1);
        check("t4_data", data_out, 8'h5A);

        // reset mid-frame, stray bits, then a clean frame
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, (i == 0), 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        n0 = nvalid;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_idle", busy, 1'b0);
        send_word(8'h81, 0, 1'b1, -1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_nvalid", nvalid - n0, 1);
        check("t5_data", data_out, 8'h81);

        // parity good and bad
        send_word(8'hA5, 0, 1'b1, 0);
        check("t6_perr0", {data_valid, parity_err}, 2'b10);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'hA5, 0, 1'b1, 1);
        check("t6_perr1", {data_valid, parity_err}, {1'b1, PB == 1});
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 300) != 0, ($urandom % 4) != 0, ($urandom % 12) == 0,
                 1'($urandom), ($urandom % 3) != 0, ($urandom % 8) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
